// File: rtl/sprite_row_loader.sv
// Double-buffered 1-bpp sprite bitmap loader: packs a byte stream into rows of a back bank and
// swaps it to the display-side front bank on frame_start. Optional macro SPRITE_MIRROR_EN adds row mirroring.
module sprite_row_loader #(
  parameter int ROWS  = 64,
  parameter int ROW_W = 64
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef SPRITE_MIRROR_EN
  input  logic                    mirror,
`endif
  input  logic                    s_valid,
  input  logic [7:0]              s_data,
  input  logic                    s_last,
  output logic                    s_ready,
  input  logic                    frame_start,
  input  logic [$clog2(ROWS)-1:0] rom_addr,
  output logic [ROW_W-1:0]        rom_data,
  output logic                    busy,
  output logic                    load_done,
  output logic                    err
);
  localparam int BPR = ROW_W / 8;
  localparam int RAW = $clog2(ROWS);
  localparam int BCW = (BPR > 1) ? $clog2(BPR) : 1;
  localparam logic [RAW-1:0] LAST_ROW  = RAW'(ROWS - 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPR - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

  state_t           state;
  logic             front_sel;
  logic [RAW-1:0]   row_cnt;
  logic [BCW-1:0]   byte_cnt;
  logic [ROW_W-1:0] row_buf;
  logic [ROW_W-1:0] bank [2][ROWS];

  logic             accept;
  logic             at_final;
  logic             row_end;
  logic             frame_err;
  logic             wr_en;
  logic [ROW_W-1:0] row_asm;
  logic [ROW_W-1:0] row_wr;

  // Stage p0: byte acceptance, framing check and row assembly
  always_comb begin
    accept    = s_valid && s_ready;
    at_final  = (row_cnt == LAST_ROW) && (byte_cnt == LAST_BYTE);
    row_end   = (byte_cnt == LAST_BYTE);
    frame_err = accept && (s_last != at_final);
    wr_en     = accept && !frame_err && row_end;
    row_asm   = row_buf;
    row_asm[{byte_cnt, 3'b000} +: 8] = s_data;
  end

`ifdef SPRITE_MIRROR_EN
  logic mirror_lat;

  function automatic logic [ROW_W-1:0] bit_rev(input logic [ROW_W-1:0] v);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < ROW_W; i++) r[i] = v[ROW_W-1-i];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      mirror_lat <= 1'b0;
    else if (accept && state == IDLE)
      mirror_lat <= mirror;
  end

  // The first byte of a load sees the live input, later bytes the latched copy.
  assign row_wr = ((state == IDLE) ? mirror : mirror_lat) ? bit_rev(row_asm) : row_asm;
`else
  assign row_wr = row_asm;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      front_sel <= 1'b0;
      row_cnt   <= '0;
      byte_cnt  <= '0;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          s_ready <= 1'b1;
          if (accept) begin
            if (frame_err) begin
              err      <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
              row_cnt  <= '0;
              byte_cnt <= '0;
            end else begin
              if (state == IDLE) err <= 1'b0;
              busy <= 1'b1;
              if (at_final) begin
                state    <= PEND;
                s_ready  <= 1'b0;
                row_cnt  <= '0;
                byte_cnt <= '0;
              end else begin
                state <= LOAD;
                if (row_end) begin
                  byte_cnt <= '0;
                  row_cnt  <= row_cnt + 1'b1;
                end else begin
                  byte_cnt <= byte_cnt + 1'b1;
                end
              end
            end
          end
        end
        PEND: begin
          if (frame_start) begin
            front_sel <= ~front_sel;
            state     <= IDLE;
            busy      <= 1'b0;
            s_ready   <= 1'b1;
            load_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: row buffer and back-bank write; writes only ever target the hidden bank
  always_ff @(posedge clk) begin
    if (accept) row_buf <= row_asm;
    if (wr_en) bank[~front_sel][row_cnt] <= row_wr;
  end

  // Stage p1: display read port, one clock of latency
  always_ff @(posedge clk) begin
    if (rst)
      rom_data <= '0;
    else
      rom_data <= bank[front_sel][rom_addr];
  end

endmodule

// File: tb/tb_sprite_row_loader.sv
// Directed, table-driven bench for sprite_row_loader; mirror checks build only with SPRITE_MIRROR_EN.
module tb_sprite_row_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_ready;
  logic        frame_start;
  logic [5:0]  rom_addr;
  logic [63:0] rom_data;
  logic        busy;
  logic        load_done;
  logic        err;
`ifdef SPRITE_MIRROR_EN
  logic        mirror;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  addr;
    logic [63:0] want;
  } rd_vec_t;

  rd_vec_t tab_a[4];
  rd_vec_t tab_b[3];

  sprite_row_loader dut (
    .clk(clk),
    .rst(rst),
`ifdef SPRITE_MIRROR_EN
    .mirror(mirror),
`endif
    .s_valid(s_valid),
    .s_data(s_data),
    .s_last(s_last),
    .s_ready(s_ready),
    .frame_start(frame_start),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .busy(busy),
    .load_done(load_done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Pattern 0: r^k, pattern 1: r^k^A5, pattern 2: single set pixel at column 0 of rows 0 and 1
  function automatic logic [7:0] pat_byte(input int sel, input int r, input int k);
    logic [7:0] b;
    b = 8'(r) ^ 8'(k);
    if (sel == 1) b = b ^ 8'hA5;
    if (sel == 2) b = (k == 0 && r < 2) ? 8'h01 : 8'h00;
    return b;
  endfunction

  function automatic logic [63:0] model_row(input int sel, input int r);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = pat_byte(sel, r, k);
    return v;
  endfunction

  task automatic send(input int sel, input int nbytes, input int last_at, input int gap_pct,
                      input int fs_period, input bit fs_on_final);
    int n;
    int cyc;
    bit acc;
    n = 0;
    cyc = 0;
    while (n < nbytes && cyc < 5000) begin
      s_valid = ($urandom_range(99) >= gap_pct);
      s_data  = pat_byte(sel, n / 8, n % 8);
      s_last  = (n == last_at);
      frame_start = (fs_period > 0 && (cyc % fs_period) == 3) ||
                    (fs_on_final && n == nbytes - 1 && s_valid);
      acc = s_valid && s_ready;
      tick();
`ifdef SPRITE_MIRROR_EN
      if (acc) mirror = 1'b0;
`endif
      if (acc) n++;
      cyc++;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    frame_start = 1'b0;
    if (n < nbytes) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got %0d bytes, required %0d", n, nbytes);
    end
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic read_row(input logic [5:0] a, input logic [63:0] req, input string name);
    rom_addr = a;
    tick();
    check(name, rom_data, req);
  endtask

  initial begin
    tab_a[0] = '{6'd5,  64'h0203000106070405};
    tab_a[1] = '{6'd0,  64'h0706050403020100};
    tab_a[2] = '{6'd63, 64'h38393A3B3C3D3E3F};
    tab_a[3] = '{6'd10, 64'h0D0C0F0E09080B0A};
    tab_b[0] = '{6'd5,  64'hA7A6A5A4A3A2A1A0};
    tab_b[1] = '{6'd0,  64'hA2A3A0A1A6A7A4A5};
    tab_b[2] = '{6'd10, 64'hA8A9AAABACADAEAF};

    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 8'h00;
    s_last = 1'b0;
    frame_start = 1'b0;
    rom_addr = 6'd0;
`ifdef SPRITE_MIRROR_EN
    mirror = 1'b0;
`endif
    tick();
    tick();
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_load_done", 64'(load_done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rom_data", rom_data, 64'd0);
    rst = 1'b0;

    // Full load of pattern A, swap, table readback
    send(0, 512, 511, 0, 0, 1'b0);
    check("a_pend_busy", 64'(busy), 64'd1);
    check("a_pend_ready", 64'(s_ready), 64'd0);
    check("a_pend_no_done", 64'(load_done), 64'd0);
    frame_pulse();
    check("a_load_done", 64'(load_done), 64'd1);
    check("a_idle_busy", 64'(busy), 64'd0);
    tick();
    check("a_load_done_pulse", 64'(load_done), 64'd0);
    for (int i = 0; i < 4; i++) read_row(tab_a[i].addr, tab_a[i].want, "rd_a_tab");
    rom_addr = 6'd5;
    tick();
    rom_addr = 6'd10;
    check("latency_hold", rom_data, 64'h0203000106070405);
    tick();
    check("latency_one", rom_data, 64'h0D0C0F0E09080B0A);

    // Pattern B with gaps and stray frame_start pulses, including one on the final byte
    send(1, 512, 511, 50, 7, 1'b1);
    check("b_pend_busy", 64'(busy), 64'd1);
    check("b_pend_no_done", 64'(load_done), 64'd0);
    for (int r = 0; r < 64; r++) begin
      check("b_pend_ready", 64'(s_ready), 64'd0);
      read_row(6'(r), model_row(0, r), "pre_swap_sweep");
    end
    rom_addr = 6'd5;
    tick();
    frame_pulse();
    check("b_load_done", 64'(load_done), 64'd1);
    check("b_swap_edge_old", rom_data, 64'h0203000106070405);
    tick();
    check("b_swap_visible", rom_data, 64'hA7A6A5A4A3A2A1A0);
    for (int i = 0; i < 3; i++) read_row(tab_b[i].addr, tab_b[i].want, "rd_b_tab");
    for (int r = 0; r < 64; r++) read_row(6'(r), model_row(1, r), "post_swap_sweep");

    // Framing errors: early s_last, then a missing s_last on the final byte
    send(0, 101, 100, 0, 0, 1'b0);
    check("early_last_err", 64'(err), 64'd1);
    check("early_last_idle", 64'(busy), 64'd0);
    check("early_last_ready", 64'(s_ready), 64'd1);
    frame_pulse();
    check("early_last_no_done", 64'(load_done), 64'd0);
    read_row(6'd5, 64'hA7A6A5A4A3A2A1A0, "early_last_no_swap");
    check("err_sticky", 64'(err), 64'd1);
    send(0, 512, -1, 0, 0, 1'b0);
    check("no_last_err", 64'(err), 64'd1);
    check("no_last_idle", 64'(busy), 64'd0);

    // Good load of A puts bank 1 in front
    send(0, 512, 511, 0, 0, 1'b0);
    check("reload_err_cleared", 64'(err), 64'd0);
    frame_pulse();
    tick();
    read_row(6'd63, 64'h38393A3B3C3D3E3F, "reload_a");

    // Reset in the middle of row 30
    send(1, 30 * 8 + 3, 511, 0, 0, 1'b0);
    check("midload_busy", 64'(busy), 64'd1);
    rom_addr = 6'd5;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_s_ready", 64'(s_ready), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    check("midrst_load_done", 64'(load_done), 64'd0);
    check("midrst_rom_data", rom_data, 64'd0);
    tick();
    check("midrst_bank0_front", rom_data, 64'hA7A6A5A4A3A2A1A0);
    send(0, 512, 511, 0, 0, 1'b0);
    frame_pulse();
    check("postrst_load_done", 64'(load_done), 64'd1);
    tick();
    for (int i = 0; i < 4; i++) read_row(tab_a[i].addr, tab_a[i].want, "postrst_rd_a");

`ifdef SPRITE_MIRROR_EN
    mirror = 1'b1;
    send(2, 512, 511, 0, 0, 1'b0);
    frame_pulse();
    tick();
    read_row(6'd0, 64'h8000_0000_0000_0000, "mirror_row0");
    read_row(6'd1, 64'h8000_0000_0000_0000, "mirror_row1_latched");
    read_row(6'd2, 64'h0, "mirror_row2");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
